stack_sequencer: RTL and testbench

//  Sequences multi-cycle stack ops (PUSH/POP/CALL/RET/RETI) between the control unit's register file and byte-wide memory.

---
 rtl/stack_sequencer_pkg.sv | 33 +++
 rtl/stack_sequencer.sv | 155 +++++++++++++++
 tb/tb_stack_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared types and constants for the stack sequencer: op encodings, FSM states
// and the per-op byte count.
package stack_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_RETI = 3'd4
  } stack_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_HI  = 3'd1,
    ST_WR_LO  = 3'd2,
    ST_RD_LO  = 3'd3,
    ST_RD_HI  = 3'd4,
    ST_FINISH = 3'd5
  } stack_seq_state_t;

  localparam int unsigned STACK_BYTES = 2;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  // PUSH and CALL store a word; everything else pops one.
  function automatic logic op_is_write(input stack_op_t op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Stack sequencer: turns 16-bit PUSH/POP/CALL/RET/RETI into two byte-wide
// memory transactions and reports the new SP, popped word and PC/IME strobes.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | waiting for start with a legal op
//  ST_WR_HI  | writing data[15:8] to sp-1
//  ST_WR_LO  | writing data[7:0]  to sp-2
//  ST_RD_LO  | reading low byte from sp
//  ST_RD_HI  | reading high byte from sp+1
//  ST_FINISH | done pulse, SP/PC/IME writeback strobes
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_push_data,
  input  logic [15:0] i_sp,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_sp_we,
  output logic [15:0] o_sp,
  output logic [15:0] o_pop_data,
  output logic        o_pc_we,
  output logic        o_ime_set
);

  localparam logic        TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LOAD = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
  localparam logic [15:0] SP_STEP = 16'(STACK_BYTES);

  stack_seq_state_t r_state;
  stack_seq_state_t w_next_state;
  stack_op_t        r_op;
  logic [15:0]      r_sp;
  logic [15:0]      r_data;
  logic [7:0]       r_lo;
  logic [15:0]      r_pop_data;
  logic [15:0]      r_wait_cnt;
  logic             r_error;

  logic w_mem_active;
  logic w_accept;
  logic w_timeout;
  logic w_cnt_load;

  assign w_mem_active = (r_state == ST_WR_HI) || (r_state == ST_WR_LO) ||
                        (r_state == ST_RD_LO) || (r_state == ST_RD_HI);
  assign w_accept     = (r_state == ST_IDLE) && i_start && op_is_legal(i_op);
  // Down-counter reaches zero on the TIMEOUT-th unacknowledged cycle of a byte.
  assign w_timeout    = TO_EN && w_mem_active && !i_mem_ack && (r_wait_cnt == 16'd0);
  assign w_cnt_load   = w_accept || (w_mem_active && i_mem_ack);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_PUSH;
      r_sp       <= 16'd0;
      r_data     <= 16'd0;
      r_lo       <= 8'd0;
      r_pop_data <= 16'd0;
      r_wait_cnt <= 16'd0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_error <= w_timeout;
      if (w_accept) begin
        r_op   <= stack_op_t'(i_op);
        r_sp   <= i_sp;
        r_data <= i_push_data;
      end
      if (w_cnt_load)
        r_wait_cnt <= TO_LOAD;
      else if (w_mem_active && !i_mem_ack && (r_wait_cnt != 16'd0))
        r_wait_cnt <= r_wait_cnt - 16'd1;
      if ((r_state == ST_RD_LO) && i_mem_ack)
        r_lo <= i_mem_rdata;
      // pop_data only changes on a completed pop, so an aborted op leaves it intact.
      if ((r_state == ST_RD_HI) && i_mem_ack)
        r_pop_data <= {i_mem_rdata, r_lo};
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = 16'd0;
    o_mem_wdata  = 8'd0;
    o_done       = 1'b0;
    o_sp_we      = 1'b0;
    o_sp         = 16'd0;
    o_pc_we      = 1'b0;
    o_ime_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_next_state = op_is_write(stack_op_t'(i_op)) ? ST_WR_HI : ST_RD_LO;
      end
      ST_WR_HI: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = r_sp - 16'd1;
        o_mem_wdata = r_data[15:8];
        if (w_timeout)      w_next_state = ST_IDLE;
        else if (i_mem_ack) w_next_state = ST_WR_LO;
      end
      ST_WR_LO: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = r_sp - 16'd2;
        o_mem_wdata = r_data[7:0];
        if (w_timeout)      w_next_state = ST_IDLE;
        else if (i_mem_ack) w_next_state = ST_FINISH;
      end
      ST_RD_LO: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_sp;
        if (w_timeout)      w_next_state = ST_IDLE;
        else if (i_mem_ack) w_next_state = ST_RD_HI;
      end
      ST_RD_HI: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_sp + 16'd1;
        if (w_timeout)      w_next_state = ST_IDLE;
        else if (i_mem_ack) w_next_state = ST_FINISH;
      end
      ST_FINISH: begin
        o_done       = 1'b1;
        o_sp_we      = 1'b1;
        o_sp         = op_is_write(r_op) ? (r_sp - SP_STEP) : (r_sp + SP_STEP);
        o_pc_we      = (r_op == OP_RET) || (r_op == OP_RETI);
        o_ime_set    = (r_op == OP_RETI);
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_error    = r_error;
  assign o_pop_data = r_pop_data;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer against a byte-array stack model with
// directed cases for wrap-around, wait states, timeout, stray inputs and reset.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] push_data;
  logic [15:0] sp_in;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy, done, error, mem_req, mem_we, sp_we, pc_we, ime_set;
  logic [15:0] mem_addr, sp_out, pop_data;
  logic [7:0]  mem_wdata;

  logic [7:0]  mem [65536];
  logic [15:0] exp_pop_hold;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  stack_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_op(op),
    .i_push_data(push_data), .i_sp(sp_in), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_done(done), .o_error(error),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_sp_we(sp_we), .o_sp(sp_out),
    .o_pop_data(pop_data), .o_pc_we(pc_we), .o_ime_set(ime_set)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    chk({tag, "_done"},  {31'd0, done},    32'd0);
    chk({tag, "_sp_we"}, {31'd0, sp_we},   32'd0);
    chk({tag, "_pc_we"}, {31'd0, pc_we},   32'd0);
    chk({tag, "_ime"},   {31'd0, ime_set}, 32'd0);
  endtask

  // One complete op with w0/w1 wait cycles before each byte's ack.
  task automatic run_op(input logic [2:0] op_v, input logic [15:0] sp_v,
                        input logic [15:0] data_v, input int w0, input int w1);
    logic [15:0] addr [2];
    logic [7:0]  wbyte [2];
    int          waits [2];
    logic        is_wr;
    logic [15:0] exp_sp;
    logic [15:0] exp_pop;
    is_wr    = (op_v == OP_PUSH) || (op_v == OP_CALL);
    waits[0] = w0;
    waits[1] = w1;
    if (is_wr) begin
      addr[0]  = sp_v - 16'd1;
      addr[1]  = sp_v - 16'd2;
      wbyte[0] = data_v[15:8];
      wbyte[1] = data_v[7:0];
      exp_sp   = sp_v - 16'd2;
      exp_pop  = exp_pop_hold;
    end else begin
      addr[0]  = sp_v;
      addr[1]  = sp_v + 16'd1;
      wbyte[0] = 8'd0;
      wbyte[1] = 8'd0;
      exp_sp   = sp_v + 16'd2;
      exp_pop  = {mem[addr[1]], mem[addr[0]]};
    end
    @(negedge clk);
    start = 1'b1; op = op_v; sp_in = sp_v; push_data = data_v; mem_ack = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w <= waits[b]; w++) begin
        chk("req",  {31'd0, mem_req}, 32'd1);
        chk("we",   {31'd0, mem_we},  {31'd0, is_wr});
        chk("addr", {16'd0, mem_addr}, {16'd0, addr[b]});
        if (is_wr) chk("wdata", {24'd0, mem_wdata}, {24'd0, wbyte[b]});
        chk("busy", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
        start     = 1'($urandom_range(0, 1));
        op        = 3'($urandom);
        sp_in     = 16'($urandom);
        push_data = 16'($urandom);
        mem_ack   = (w == waits[b]);
        mem_rdata = (mem_ack && !is_wr) ? mem[addr[b]] : 8'($urandom);
        if (mem_ack && is_wr) mem[addr[b]] = wbyte[b];
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    start   = 1'b0;
    chk("done",    {31'd0, done},    32'd1);
    chk("sp_we",   {31'd0, sp_we},   32'd1);
    chk("sp_o",    {16'd0, sp_out},  {16'd0, exp_sp});
    chk("pc_we",   {31'd0, pc_we},   {31'd0, (op_v == OP_RET) || (op_v == OP_RETI)});
    chk("ime_set", {31'd0, ime_set}, {31'd0, op_v == OP_RETI});
    chk("req_fin", {31'd0, mem_req}, 32'd0);
    chk("err_fin", {31'd0, error},   32'd0);
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_once", {31'd0, done}, 32'd0);
    chk("busy_post", {31'd0, busy}, 32'd0);
    chk("pop_data",  {16'd0, pop_data}, {16'd0, exp_pop});
    chk("req_idle",  {31'd0, mem_req}, 32'd0);
    exp_pop_hold = exp_pop;
    mem_ack = 1'b0;
  endtask

  task automatic run_pop_timeout(input logic [15:0] sp_v);
    @(negedge clk);
    start = 1'b1; op = OP_POP; sp_in = sp_v; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_req",  {31'd0, mem_req}, 32'd1);
      chk("to_addr", {16'd0, mem_addr}, {16'd0, sp_v});
      chk("to_err_early", {31'd0, error}, 32'd0);
      @(negedge clk);
    end
    chk("to_error", {31'd0, error}, 32'd1);
    chk_quiet("to");
    @(negedge clk);
    chk("to_err_once", {31'd0, error}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_pop",  {16'd0, pop_data}, {16'd0, exp_pop_hold});
  endtask

  task automatic run_reset_in_wr_lo(input logic [15:0] sp_v, input logic [15:0] data_v);
    @(negedge clk);
    start = 1'b1; op = OP_PUSH; sp_in = sp_v; push_data = data_v;
    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b1;
    mem[sp_v - 16'd1] = data_v[15:8];
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rst_pre_addr", {16'd0, mem_addr}, {16'd0, 16'(sp_v - 16'd2)});
    nrst = 1'b0;
    #1;
    chk_quiet("rst");
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pop",  {16'd0, pop_data}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    exp_pop_hold = 16'd0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [15:0] sp_r;
    int          w0, w1;
    nrst = 1'b0; start = 1'b0; op = 3'd0; push_data = 16'd0; sp_in = 16'd0;
    mem_ack = 1'b0; mem_rdata = 8'd0; exp_pop_hold = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    #12;
    chk_quiet("reset");
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    chk("reset_pop",   {16'd0, pop_data}, 32'd0);
    chk("reset_sp_o",  {16'd0, sp_out},   32'd0);
    @(negedge clk);
    nrst = 1'b1;

    run_op(OP_PUSH, 16'hFFFE, 16'h12AB, 0, 0);
    chk("push_mem_hi", {24'd0, mem[16'hFFFD]}, 32'h12);
    chk("push_mem_lo", {24'd0, mem[16'hFFFC]}, 32'hAB);
    mem[16'hC000] = 8'h34;
    mem[16'hC001] = 8'h12;
    run_op(OP_RETI, 16'hC000, 16'h0000, 2, 2);
    chk("reti_pop", {16'd0, exp_pop_hold}, 32'h1234);
    run_op(OP_PUSH, 16'h0000, 16'hBEEF, 0, 1);
    run_op(OP_POP,  16'hFFFF, 16'h0000, 1, 0);
    run_op(OP_CALL, 16'h0001, 16'h5A5A, 15, 0);
    run_op(OP_RET,  16'hFFFF, 16'h0000, 0, 15);
    run_pop_timeout(16'h8000);

    for (int k = 5; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(k); sp_in = 16'h4000;
      @(negedge clk);
      start = 1'b0;
      chk("illegal_busy", {31'd0, busy}, 32'd0);
      chk("illegal_req",  {31'd0, mem_req}, 32'd0);
    end

    run_reset_in_wr_lo(16'h2000, 16'hCAFE);
    run_op(OP_PUSH, 16'h2000, 16'h0F0F, 0, 0);
    run_op(OP_POP,  16'h1FFE, 16'h0000, 0, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       sp_r = 16'h0000;
        1:       sp_r = 16'hFFFF;
        default: sp_r = 16'($urandom);
      endcase
      w0 = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      w1 = int'($urandom_range(0, 3));
      run_op(3'($urandom_range(0, 4)), sp_r, 16'($urandom), w0, w1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
